// File: rtl/speech_clip_player.sv
// Speech clip player: maps a number to audio clips, fetches clip bytes over req/ack, plays one byte per sample_tick.
// Latency: map results sampled MAP_LAT cycles after map_number; audio_out updates one cycle after sample_tick.
// Backpressure: one read outstanding, fetch stalls while the FIFO is full; SPEECH_PLAYER_UNDERRUN_CNT_EN adds underrun_cnt.

module speech_clip_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Caller never writes when full nor reads when empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_vld);
        rd_ptr_d = rd_ptr_q + AW'(rd_rdy);
        count_d  = count_q + CW'(wr_vld) - CW'(rd_rdy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;
endmodule

module speech_clip_player #(
    parameter int         FIFO_DEPTH  = 16,
    parameter int         MAP_LAT     = 2,
    parameter int         MAX_CLIPS   = 4,
    parameter logic [7:0] IDLE_SAMPLE = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  number,
    output logic        busy,
    output logic        done,
    output logic [7:0]  map_number,
    input  logic [31:0] map_start_adr,
    input  logic [31:0] map_stop_adr,
    input  logic [7:0]  map_out_number,
    output logic        rd_req,
    output logic [31:0] rd_adr,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    input  logic        sample_tick,
    output logic [7:0]  audio_out,
    output logic [2:0]  clip_count
`ifdef SPEECH_PLAYER_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(MAP_LAT + 2);
    localparam logic [2:0] MAX_CLIPS_C = 3'(MAX_CLIPS);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MAP_WAIT = 2'd1;
    localparam logic [1:0] S_PLAY     = 2'd2;
    localparam logic [1:0] S_FINISH   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [7:0]    map_number_q, map_number_d;
    logic [31:0]   cur_adr_q, cur_adr_d, stop_adr_q, stop_adr_d;
    logic [7:0]    next_num_q, next_num_d;
    logic [2:0]    clip_count_q, clip_count_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          rd_req_q, rd_req_d;
    logic [31:0]   rd_adr_q, rd_adr_d;
    logic [7:0]    audio_q, audio_d;
`ifdef SPEECH_PLAYER_UNDERRUN_CNT_EN
    logic [15:0]   underrun_q, underrun_d;
`endif

    logic          fifo_wr, fifo_rd;
    logic [7:0]    fifo_dat;
    logic [CW-1:0] fifo_cnt;

    assign fifo_wr = rd_req_q & rd_ack;
    assign fifo_rd = (state_q == S_PLAY) & sample_tick & (fifo_cnt != '0);

    speech_clip_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (fifo_wr),
        .wr_dat (rd_data),
        .rd_rdy (fifo_rd),
        .rd_dat (fifo_dat),
        .count  (fifo_cnt)
    );

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        map_number_d = map_number_q;
        cur_adr_d    = cur_adr_q;
        stop_adr_d   = stop_adr_q;
        next_num_d   = next_num_q;
        clip_count_d = clip_count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_req_d     = rd_req_q;
        rd_adr_d     = rd_adr_q;
        audio_d      = audio_q;
`ifdef SPEECH_PLAYER_UNDERRUN_CNT_EN
        underrun_d   = underrun_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sample_tick) audio_d = IDLE_SAMPLE;
                if (start) begin
                    clip_count_d = '0;
`ifdef SPEECH_PLAYER_UNDERRUN_CNT_EN
                    underrun_d   = '0;
`endif
                    if (number != 8'd0) begin
                        map_number_d = number;
                        busy_d       = 1'b1;
                        lat_d        = '0;
                        state_d      = S_MAP_WAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_MAP_WAIT: begin
                if (lat_q == LW'(MAP_LAT)) begin
                    cur_adr_d  = map_start_adr;
                    stop_adr_d = map_stop_adr;
                    next_num_d = map_out_number;
                    if (map_start_adr >= map_stop_adr) begin
                        state_d = S_FINISH;
                    end else begin
                        clip_count_d = clip_count_q + 3'd1;
                        state_d      = S_PLAY;
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_PLAY: begin
                // With no request in flight the outstanding term is zero.
                if (rd_req_q) begin
                    if (rd_ack) begin
                        rd_req_d  = 1'b0;
                        cur_adr_d = cur_adr_q + 32'd1;
                    end
                end else if (cur_adr_q < stop_adr_q && fifo_cnt < CW'(FIFO_DEPTH)) begin
                    rd_req_d = 1'b1;
                    rd_adr_d = cur_adr_q;
                end
                if (sample_tick) begin
                    if (fifo_cnt != '0) begin
                        audio_d = fifo_dat;
                    end
`ifdef SPEECH_PLAYER_UNDERRUN_CNT_EN
                    else if (underrun_q != 16'hFFFF) begin
                        underrun_d = underrun_q + 16'd1;
                    end
`endif
                end
                if (!rd_req_q && cur_adr_q == stop_adr_q && fifo_cnt == '0) begin
                    if (next_num_q != 8'd0 && clip_count_q < MAX_CLIPS_C) begin
                        map_number_d = next_num_q;
                        lat_d        = '0;
                        state_d      = S_MAP_WAIT;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            default: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lat_q        <= '0;
            map_number_q <= '0;
            cur_adr_q    <= '0;
            stop_adr_q   <= '0;
            next_num_q   <= '0;
            clip_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_adr_q     <= '0;
            audio_q      <= IDLE_SAMPLE;
`ifdef SPEECH_PLAYER_UNDERRUN_CNT_EN
            underrun_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            map_number_q <= map_number_d;
            cur_adr_q    <= cur_adr_d;
            stop_adr_q   <= stop_adr_d;
            next_num_q   <= next_num_d;
            clip_count_q <= clip_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_req_q     <= rd_req_d;
            rd_adr_q     <= rd_adr_d;
            audio_q      <= audio_d;
`ifdef SPEECH_PLAYER_UNDERRUN_CNT_EN
            underrun_q   <= underrun_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign map_number = map_number_q;
    assign rd_req     = rd_req_q;
    assign rd_adr     = rd_adr_q;
    assign audio_out  = audio_q;
    assign clip_count = clip_count_q;
`ifdef SPEECH_PLAYER_UNDERRUN_CNT_EN
    assign underrun_cnt = underrun_q;
`endif
endmodule
